// File: rtl/shift_pkg.sv
// Constants shared by the iterative shift sequencer and its barrel shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int STEP_W   = 3;
  localparam int STEP_MAX = (1 << STEP_W) - 1;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logical barrel shifter, zero fill. It is built as log2 stages, and
// each stage moves the data by a power of two.
module barrel_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 3
) (
  input  logic [WIDTH-1:0]  in,
  input  logic [STEP_W-1:0] shamt,
  input  logic              dir,
  output logic [WIDTH-1:0]  out
);

  logic [WIDTH-1:0] stage [0:STEP_W];

  assign stage[0] = in;

  for (genvar gi = 0; gi < STEP_W; gi++) begin : g_stage
    assign stage[gi+1] = !shamt[gi]        ? stage[gi] :
                         (dir == DIR_RIGHT) ? (stage[gi] >> (1 << gi)) :
                                              (stage[gi] << (1 << gi));
  end

  assign out = stage[STEP_W];

endmodule

// File: rtl/iter_shift_ctrl.sv
// Iterative shift sequencer. It splits a large shift amount into barrel-shifter steps
// and returns the result over a valid/ready port.
// Optional build macro SAT_SHORTCUT_EN lets a result that is already all-zero skip the
// remaining steps.
module iter_shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int AMT_W  = 8,
  parameter int STEP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [AMT_W-1:0] STEP_LIM = AMT_W'((1 << STEP_W) - 1);
`ifdef SAT_SHORTCUT_EN
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
`endif

  state_e            state_q;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic              dir_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [STEP_W-1:0] step;
  logic              last_step;

  always_comb begin
    step      = (rem_q > STEP_LIM) ? STEP_W'(STEP_LIM) : rem_q[STEP_W-1:0];
    last_step = (rem_q <= STEP_LIM);
    rem_d     = rem_q - AMT_W'(step);
`ifdef SAT_SHORTCUT_EN
    last_step = last_step || (data_d == '0);
`endif
  end

  barrel_shifter #(
    .WIDTH (WIDTH),
    .STEP_W(STEP_W)
  ) u_bs (
    .in   (data_q),
    .shamt(step),
    .dir  (dir_q),
    .out  (data_d)
  );

  // req_ready is the only unregistered output. It must drop as soon as rst rises.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            dir_q  <= req_dir;
            rem_q  <= req_amt;
            busy_q <= 1'b1;
            if (req_amt == '0) begin
              data_q      <= req_data;
              out_data_q  <= req_data;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
`ifdef SAT_SHORTCUT_EN
            end else if (req_amt >= WIDTH_AMT) begin
              data_q      <= '0;
              rem_q       <= '0;
              out_data_q  <= '0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
`endif
            end else begin
              data_q  <= req_data;
              state_q <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          data_q <= data_d;
          rem_q  <= rem_d;
          if (last_step) begin
            out_data_q  <= data_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Directed bench for iter_shift_ctrl. It checks the result data, the latency, the
// hold-until-taken behaviour and reset applied mid-operation.
module tb_iter_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [7:0] req_amt;
  logic       req_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       out_ready_tie;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iter_shift_ctrl #(.WIDTH(8), .AMT_W(8), .STEP_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_amt  (req_amt),
    .req_dir  (req_dir),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] d, input logic [7:0] a, input logic dr);
    int w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_data  = d;
    req_amt   = a;
    req_dir   = dr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = 8'h00;
    req_amt   = 8'h00;
  endtask

  // Runs one transaction. The exp_lat argument counts clock edges from the accept edge
  // (which counts as 1) until out_valid is high.
  task automatic run_req(input logic [7:0] d, input logic [7:0] a, input logic dr,
                         input logic [7:0] exp, input int exp_lat, input int hold);
    int cnt = 1;
    start_req(d, a, dr);
    while (!out_valid && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    check_eq("out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("latency", cnt, exp_lat);
    check_eq("out_data", {24'd0, out_data}, {24'd0, exp});
    $display("txn data=0x%02h amt=%0d dir=%0d out=0x%02h exp=0x%02h lat=%0d",
             d, a, dr, out_data, exp, cnt);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_data", {24'd0, out_data}, {24'd0, exp});
      check_eq("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = out_ready_tie;
    check_eq("post_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("post_busy", {31'd0, busy}, 32'd0);
  endtask

  function automatic int lat_of(input logic [7:0] a);
    return (a == 8'd0) ? 1 : ((int'(a) + 6) / 7) + 1;
  endfunction

  logic [7:0] vd [6] = '{8'hC3, 8'hC3, 8'hFF, 8'h81, 8'h3C, 8'hF0};
  logic [7:0] va [6] = '{8'd3,  8'd3,  8'd9,  8'd1,  8'd255, 8'd4};
  logic       vr [6] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};

  initial begin
    logic [7:0] model;
    rst = 1'b1; req_valid = 1'b0; req_data = 8'h00; req_amt = 8'h00;
    req_dir = 1'b0; out_ready = 1'b0; out_ready_tie = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("idle_req_ready", {31'd0, req_ready}, 32'd1);

    run_req(8'h5D, 8'd2, 1'b0, 8'h74, 2, 0);
    run_req(8'h5D, 8'd2, 1'b1, 8'h17, 2, 0);
`ifndef SAT_SHORTCUT_EN
    run_req(8'h80, 8'd8, 1'b1, 8'h00, 3, 0);
`else
    run_req(8'h80, 8'd8, 1'b1, 8'h00, 1, 0);
`endif
    run_req(8'hA5, 8'd0, 1'b0, 8'hA5, 1, 0);
    run_req(8'h01, 8'd7, 1'b0, 8'h80, 2, 5);

    // Apply reset while a 200-bit shift is still iterating.
    start_req(8'hFF, 8'd200, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mrst_busy", {31'd0, busy}, 32'd0);
    check_eq("mrst_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("after_rst_req_ready", {31'd0, req_ready}, 32'd1);
    run_req(8'h0F, 8'd3, 1'b0, 8'h78, 2, 0);

    out_ready_tie = 1'b1;
    out_ready     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      model = vr[i] ? (vd[i] >> va[i]) : (vd[i] << va[i]);
`ifndef SAT_SHORTCUT_EN
      run_req(vd[i], va[i], vr[i], model, lat_of(va[i]), 0);
`else
      start_req(vd[i], va[i], vr[i]);
      begin
        int w = 0;
        while (!out_valid && w < 200) begin
          @(posedge clk); #1; w++;
        end
      end
      check_eq("sc_data", {24'd0, out_data}, {24'd0, model});
      $display("txn data=0x%02h amt=%0d dir=%0d out=0x%02h exp=0x%02h",
               vd[i], va[i], vr[i], out_data, model);
      @(posedge clk); #1;
      check_eq("sc_req_ready", {31'd0, req_ready}, 32'd1);
`endif
    end
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
